// File: rtl/minhash_proj_top.sv
// MinHash fragment extender: serializes one packed word of 2-bit bases into one-hot parts.
// Optional build macro PROJ_TOP_REVCOMP_EN emits each part as its reverse complement.

package proj_pkg;
    localparam int BASE_LEN                      = 32;
    localparam int PART_BASES                    = 4;
    localparam int EXTENDER_OUT_PART_LEN_ONE_HOT = 4 * PART_BASES;
endpackage

module minhash_proj_top #(
    parameter int BASE_LEN                      = proj_pkg::BASE_LEN,
    parameter int PART_BASES                    = proj_pkg::PART_BASES,
    parameter int EXTENDER_OUT_PART_LEN_ONE_HOT = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [BASE_LEN-1:0]                      in_data,
    output logic [EXTENDER_OUT_PART_LEN_ONE_HOT-1:0] out_fragment,
    output logic                                     out_wait
);
    localparam int NUM_PARTS = BASE_LEN / (2 * PART_BASES);
    localparam int SEG_W     = 2 * PART_BASES;
    localparam int OUT_W     = EXTENDER_OUT_PART_LEN_ONE_HOT;
    localparam int PART_W    = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam logic [PART_W-1:0] LAST_PART = PART_W'(NUM_PARTS - 1);

    logic [BASE_LEN-1:0] word_q, word_d;
    logic [PART_W-1:0]   part_q, part_d;
    logic                busy_q, busy_d;
    logic [OUT_W-1:0]    frag_q, frag_d;

    // Packed view of the held word, one element per part.
    logic [NUM_PARTS-1:0][SEG_W-1:0] word_parts;
    assign word_parts = word_q;

    function automatic logic [OUT_W-1:0] encode_part(input logic [SEG_W-1:0] seg);
        logic [3:0] nib;
        encode_part = '0;
        for (int j = 0; j < PART_BASES; j++) begin
            nib = 4'b0001 << seg[2*j +: 2];
`ifdef PROJ_TOP_REVCOMP_EN
            // Complement swaps A<->T and C<->G, i.e. bit-reverses the one-hot nibble.
            encode_part[4*(PART_BASES-1-j) +: 4] = {nib[0], nib[1], nib[2], nib[3]};
`else
            encode_part[4*j +: 4] = nib;
`endif
        end
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        word_d = word_q;
        part_d = part_q;
        busy_d = busy_q;
        frag_d = frag_q;
        if (!busy_q) begin
            word_d = in_data;
            frag_d = encode_part(in_data[SEG_W-1:0]);
            if (NUM_PARTS > 1) begin
                part_d = PART_W'(1);
                busy_d = 1'b1;
            end
        end else begin
            frag_d = encode_part(word_parts[part_q]);
            if (part_q == LAST_PART) begin
                part_d = '0;
                busy_d = 1'b0;
            end else begin
                part_d = part_q + PART_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            part_q <= '0;
            busy_q <= 1'b0;
            frag_q <= '0;
        end else begin
            word_q <= word_d;
            part_q <= part_d;
            busy_q <= busy_d;
            frag_q <= frag_d;
        end
    end

    assign out_fragment = frag_q;
    assign out_wait     = busy_q;

endmodule

// File: tb/tb_minhash_proj_top.sv
// Directed and scoreboarded bench for minhash_proj_top (forward or PROJ_TOP_REVCOMP_EN build).

module tb_minhash_proj_top;
    localparam int BL  = proj_pkg::BASE_LEN;
    localparam int PB  = proj_pkg::PART_BASES;
    localparam int OW  = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT;
    localparam int NP  = BL / (2 * PB);

`ifdef PROJ_TOP_REVCOMP_EN
    localparam logic [OW-1:0] EXP_E4_P0   = 16'h8421;
    localparam logic [OW-1:0] EXP_E4_TAIL = 16'h8888;
    localparam logic [OW-1:0] EXP_ONES    = 16'h1111;
    localparam logic [OW-1:0] EXP_ZEROS   = 16'h8888;
    localparam logic [OW-1:0] EXP_1234_P0 = 16'h8214;
    localparam logic [OW-1:0] EXP_1234_P1 = 16'h2444;
`else
    localparam logic [OW-1:0] EXP_E4_P0   = 16'h8421;
    localparam logic [OW-1:0] EXP_E4_TAIL = 16'h1111;
    localparam logic [OW-1:0] EXP_ONES    = 16'h8888;
    localparam logic [OW-1:0] EXP_ZEROS   = 16'h1111;
    localparam logic [OW-1:0] EXP_1234_P0 = 16'h2841;
    localparam logic [OW-1:0] EXP_1234_P1 = 16'h2224;
`endif

    logic          clk;
    logic          rst_n;
    logic [BL-1:0] in_data;
    logic [OW-1:0] out_fragment;
    logic          out_wait;

    int n_cmp = 0;
    int n_bad = 0;

    minhash_proj_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .out_fragment (out_fragment),
        .out_wait     (out_wait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode by base lookup; reverse complement places ~base at the mirrored slot.
    function automatic logic [OW-1:0] ref_part(input logic [BL-1:0] w, input int p);
        logic [1:0] b;
        logic [3:0] nib;
        int         pos;
        ref_part = '0;
        for (int j = 0; j < PB; j++) begin
            b = w[2*(p*PB + j) +: 2];
`ifdef PROJ_TOP_REVCOMP_EN
            b   = ~b;
            pos = PB - 1 - j;
`else
            pos = j;
`endif
            case (b)
                2'b00:   nib = 4'b0001;
                2'b01:   nib = 4'b0010;
                2'b10:   nib = 4'b0100;
                default: nib = 4'b1000;
            endcase
            ref_part[4*pos +: 4] = nib;
        end
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_fragment !== '0) begin
            n_bad++;
            $display("FAIL reset_fragment: got %h expected %h", out_fragment, {OW{1'b0}});
        end
        n_cmp++;
        if (out_wait !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wait: got %b expected 0", out_wait);
        end
        // Release, accept a word, then assert reset between edges.
        in_data = '1;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_fragment !== EXP_ONES) begin
            n_bad++;
            $display("FAIL pre_async_fragment: got %h expected %h", out_fragment, EXP_ONES);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_fragment !== '0) begin
            n_bad++;
            $display("FAIL async_reset_fragment: got %h expected 0", out_fragment);
        end
        n_cmp++;
        if (out_wait !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_wait: got %b expected 0", out_wait);
        end
        @(posedge clk);
        #1;
    endtask

    // Releases reset; the first edge must accept 0xE4. in_data switches to all-T during waits.
    task automatic test_encoding();
        logic [OW-1:0] exp_f;
        in_data = 32'h0000_00E4;
        rst_n   = 1'b1;
        for (int k = 0; k < NP; k++) begin
            @(posedge clk);
            #1;
            exp_f = (k == 0) ? EXP_E4_P0 : EXP_E4_TAIL;
            n_cmp++;
            if (out_fragment !== exp_f) begin
                n_bad++;
                $display("FAIL encoding_part%0d: got %h expected %h", k, out_fragment, exp_f);
            end
            n_cmp++;
            if (out_wait !== (k != NP - 1)) begin
                n_bad++;
                $display("FAIL encoding_wait%0d: got %b expected %b", k, out_wait, k != NP - 1);
            end
            if (k == 0) in_data = 32'hFFFF_FFFF;
        end
    endtask

    task automatic test_back_pressure();
        for (int k = 0; k < NP; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_fragment !== EXP_ONES) begin
                n_bad++;
                $display("FAIL bp_part%0d: got %h expected %h", k, out_fragment, EXP_ONES);
            end
            n_cmp++;
            if (out_wait !== (k != NP - 1)) begin
                n_bad++;
                $display("FAIL bp_wait%0d: got %b expected %b", k, out_wait, k != NP - 1);
            end
        end
    endtask

    task automatic test_streaming();
        logic [BL-1:0] w;
        logic [OW-1:0] exp_f;
        for (int n = 0; n < 1000; n++) begin
            w       = BL'($urandom);
            in_data = w;
            for (int k = 0; k < NP; k++) begin
                @(posedge clk);
                #1;
                exp_f = ref_part(w, k);
                n_cmp++;
                if (out_fragment !== exp_f) begin
                    n_bad++;
                    $display("FAIL stream_w%0d_p%0d: got %h expected %h", n, k, out_fragment, exp_f);
                end
                n_cmp++;
                if (out_wait !== (k != NP - 1)) begin
                    n_bad++;
                    $display("FAIL stream_wait_w%0d_p%0d: got %b expected %b", n, k, out_wait, k != NP - 1);
                end
                if (k == 0) in_data = ~w;
            end
        end
    endtask

    task automatic test_mid_word_reset();
        logic [OW-1:0] exp_f;
        in_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_fragment !== EXP_1234_P0) begin
            n_bad++;
            $display("FAIL midrst_part0: got %h expected %h", out_fragment, EXP_1234_P0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_fragment !== EXP_1234_P1) begin
            n_bad++;
            $display("FAIL midrst_part1: got %h expected %h", out_fragment, EXP_1234_P1);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_fragment !== '0 || out_wait !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_clear: got frag %h wait %b expected 0/0", out_fragment, out_wait);
        end
        in_data = 32'h0000_00E4;
        #1 rst_n = 1'b1;
        for (int k = 0; k < NP; k++) begin
            @(posedge clk);
            #1;
            exp_f = (k == 0) ? EXP_E4_P0 : EXP_E4_TAIL;
            n_cmp++;
            if (out_fragment !== exp_f || out_wait !== (k != NP - 1)) begin
                n_bad++;
                $display("FAIL midrst_restart_p%0d: got frag %h wait %b expected %h/%b",
                         k, out_fragment, out_wait, exp_f, k != NP - 1);
            end
        end
    endtask

    task automatic test_revcomp();
        in_data = '0;
        for (int k = 0; k < NP; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_fragment !== EXP_ZEROS) begin
                n_bad++;
                $display("FAIL zeros_part%0d: got %h expected %h", k, out_fragment, EXP_ZEROS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_back_pressure();
        test_streaming();
        test_mid_word_reset();
        test_revcomp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
